// File: rtl/i2s_rx_deser.sv
// I2S receive deserializer: synchronizes the codec's SCLK/LRCLK/SDATA into Clk,
// captures one left/right frame at a time and holds it behind a valid/ready handshake.
// Optional sticky dropped-frame flag 'overrun' is built only when I2S_RX_OVERRUN_EN is defined.
module i2s_rx_deser #(
    parameter int DATA_W = 16
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              sclk_in,
    input  logic              lrclk_in,
    input  logic              din_in,
    output logic [DATA_W-1:0] out_left,
    output logic [DATA_W-1:0] out_right,
    output logic              out_valid,
    input  logic              out_ready
`ifdef I2S_RX_OVERRUN_EN
    ,
    output logic              overrun
`endif
);

    localparam int IDX_W = $clog2(DATA_W);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        ALIGN,
        SHIFT_L,
        WAIT_L,
        SHIFT_R,
        WAIT_R
    } state_t;

    state_t state_q, state_d;

    logic sclk_meta_q, sclk_meta_d;
    logic sclk_sync_q, sclk_sync_d;
    logic sclk_prev_q, sclk_prev_d;
    logic lr_meta_q, lr_meta_d;
    logic lr_sync_q, lr_sync_d;
    logic din_meta_q, din_meta_d;
    logic din_sync_q, din_sync_d;
    logic lr_prev_q, lr_prev_d;

    logic [IDX_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  bit_idx;
    logic [DATA_W-1:0] capture_q, capture_d;
    logic [DATA_W-1:0] capture_next;
    logic [DATA_W-1:0] left_hold_q, left_hold_d;
    logic [DATA_W-1:0] frame_right;

    logic [DATA_W-1:0] out_left_q, out_left_d;
    logic [DATA_W-1:0] out_right_q, out_right_d;
    logic              out_valid_q, out_valid_d;
`ifdef I2S_RX_OVERRUN_EN
    logic              overrun_q, overrun_d;
`endif

    logic sclk_rise;
    logic delay_slot;
    logic frame_done;
    logic start_left;
    logic start_right;
    logic accept;

    // A delay slot is the first rise carrying a new LRCLK level; that bit belongs to no channel.
    always_comb begin
        sclk_meta_d = sclk_in;
        sclk_sync_d = sclk_meta_q;
        sclk_prev_d = sclk_sync_q;
        lr_meta_d   = lrclk_in;
        lr_sync_d   = lr_meta_q;
        din_meta_d  = din_in;
        din_sync_d  = din_meta_q;
        sclk_rise   = sclk_sync_q & ~sclk_prev_q;
        delay_slot  = sclk_rise & (lr_sync_q ^ lr_prev_q);
        lr_prev_d   = sclk_rise ? lr_sync_q : lr_prev_q;
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        capture_d   = capture_q;
        left_hold_d = left_hold_q;
        frame_done  = 1'b0;
        frame_right = capture_q;
        start_left  = 1'b0;
        start_right = 1'b0;

        // Bits land at their final MSB-first position, so a short slot is already zero-filled.
        bit_idx               = LAST_IDX - cnt_q;
        capture_next          = capture_q;
        capture_next[bit_idx] = din_sync_q;

        if (sclk_rise) begin
            case (state_q)
                ALIGN: begin
                    if (delay_slot && !lr_sync_q) begin
                        start_left = 1'b1;
                    end
                end
                SHIFT_L: begin
                    if (delay_slot) begin
                        if (lr_sync_q) begin
                            left_hold_d = capture_q;
                            start_right = 1'b1;
                        end else begin
                            state_d = ALIGN;
                        end
                    end else begin
                        capture_d = capture_next;
                        if (cnt_q == LAST_IDX) begin
                            left_hold_d = capture_next;
                            state_d     = WAIT_L;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_L: begin
                    if (delay_slot) begin
                        if (lr_sync_q) begin
                            start_right = 1'b1;
                        end else begin
                            state_d = ALIGN;
                        end
                    end
                end
                SHIFT_R: begin
                    if (delay_slot) begin
                        frame_done  = 1'b1;
                        frame_right = capture_q;
                        start_left  = 1'b1;
                    end else begin
                        capture_d = capture_next;
                        if (cnt_q == LAST_IDX) begin
                            frame_done  = 1'b1;
                            frame_right = capture_next;
                            state_d     = WAIT_R;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                WAIT_R: begin
                    if (delay_slot && !lr_sync_q) begin
                        start_left = 1'b1;
                    end
                end
                default: begin
                    state_d = ALIGN;
                end
            endcase
        end

        if (start_left) begin
            state_d   = SHIFT_L;
            cnt_d     = '0;
            capture_d = '0;
        end
        if (start_right) begin
            state_d   = SHIFT_R;
            cnt_d     = '0;
            capture_d = '0;
        end
    end

    // A finished frame replaces the held one only if the held one is gone or leaving this cycle.
    always_comb begin
        out_left_d  = out_left_q;
        out_right_d = out_right_q;
        out_valid_d = out_valid_q;
        accept      = frame_done & (~out_valid_q | out_ready);

        if (accept) begin
            out_left_d  = left_hold_q;
            out_right_d = frame_right;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready && !frame_done) begin
            out_valid_d = 1'b0;
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    always_comb begin
        overrun_d = overrun_q | (frame_done & ~accept);
    end
`endif

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= ALIGN;
            sclk_meta_q <= 1'b0;
            sclk_sync_q <= 1'b0;
            sclk_prev_q <= 1'b0;
            lr_meta_q   <= 1'b0;
            lr_sync_q   <= 1'b0;
            din_meta_q  <= 1'b0;
            din_sync_q  <= 1'b0;
            lr_prev_q   <= 1'b0;
            cnt_q       <= '0;
            capture_q   <= '0;
            left_hold_q <= '0;
            out_left_q  <= '0;
            out_right_q <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sclk_meta_q <= sclk_meta_d;
            sclk_sync_q <= sclk_sync_d;
            sclk_prev_q <= sclk_prev_d;
            lr_meta_q   <= lr_meta_d;
            lr_sync_q   <= lr_sync_d;
            din_meta_q  <= din_meta_d;
            din_sync_q  <= din_sync_d;
            lr_prev_q   <= lr_prev_d;
            cnt_q       <= cnt_d;
            capture_q   <= capture_d;
            left_hold_q <= left_hold_d;
            out_left_q  <= out_left_d;
            out_right_q <= out_right_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef I2S_RX_OVERRUN_EN
    always_ff @(posedge Clk) begin
        if (Reset) begin
            overrun_q <= 1'b0;
        end else begin
            overrun_q <= overrun_d;
        end
    end

    assign overrun = overrun_q;
`endif

    assign out_left  = out_left_q;
    assign out_right = out_right_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: a codec model drives I2S frames, a scoreboard checks every accepted frame.
// Each half-frame is one LRCLK-transition bit followed by 'payload' data-bearing bits.
`timescale 1ns/1ps
module tb_i2s_rx_deser;

    typedef struct packed {
        logic [15:0] l;
        logic [15:0] r;
    } frame_t;

    logic Clk = 1'b0;
    logic Reset;
    logic sclk;
    logic lrclk;
    logic din;
    logic out_ready16;
    logic out_ready24 = 1'b1;

    logic [15:0] out_left16, out_right16;
    logic        out_valid16;
    logic [23:0] out_left24, out_right24;
    logic        out_valid24;
`ifdef I2S_RX_OVERRUN_EN
    logic        overrun16, overrun24;
`endif

    int assertions = 0;
    int failures   = 0;
    int half_acc   = 0;

    frame_t exp_q[$];
    event right_start_ev;
    event last_right_bit_ev;
    realtime last_bit_time   = 0.0;
    realtime valid_rise_time = 0.0;
    logic    prev_valid16    = 1'b0;

    bit          armed24 = 1'b0;
    bit          got24   = 1'b0;
    logic [23:0] left24  = '0;
    logic [23:0] right24 = '0;

    i2s_rx_deser #(.DATA_W(16)) dut16 (
        .Clk       (Clk),
        .Reset     (Reset),
        .sclk_in   (sclk),
        .lrclk_in  (lrclk),
        .din_in    (din),
        .out_left  (out_left16),
        .out_right (out_right16),
        .out_valid (out_valid16),
        .out_ready (out_ready16)
`ifdef I2S_RX_OVERRUN_EN
        ,
        .overrun   (overrun16)
`endif
    );

    i2s_rx_deser #(.DATA_W(24)) dut24 (
        .Clk       (Clk),
        .Reset     (Reset),
        .sclk_in   (sclk),
        .lrclk_in  (lrclk),
        .din_in    (din),
        .out_left  (out_left24),
        .out_right (out_right24),
        .out_valid (out_valid24),
        .out_ready (out_ready24)
`ifdef I2S_RX_OVERRUN_EN
        ,
        .overrun   (overrun24)
`endif
    );

    always #10 Clk = ~Clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertions++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic pop_and_check();
        frame_t e;
        assertions++;
        assert (exp_q.size() > 0) else begin
            failures++;
            $error("[TB] FAIL unexpected_frame: observed %h/%h expected no frame", out_left16, out_right16);
        end
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("frame_left", {16'h0, out_left16}, {16'h0, e.l});
            checkOutput("frame_right", {16'h0, out_right16}, {16'h0, e.r});
        end
    endtask

    // Scoreboard side: every handshake on the 16-bit instance consumes one expected frame.
    always @(negedge Clk) begin
        if (!Reset) begin
            if (out_valid16 && !prev_valid16) begin
                valid_rise_time <= $realtime;
            end
            if (out_valid16 && out_ready16) begin
                pop_and_check();
            end
        end
        prev_valid16 <= out_valid16;
    end

    always @(negedge Clk) begin
        if (!Reset && armed24 && !got24 && out_valid24) begin
            got24   <= 1'b1;
            left24  <= out_left24;
            right24 <= out_right24;
        end
    end

    // Fractional half-period so the average bit clock is 3.072 MHz against a 50 MHz Clk.
    task automatic wait_half();
        int n;
        half_acc = half_acc + 8138;
        n        = half_acc / 1000;
        half_acc = half_acc % 1000;
        repeat (n) @(posedge Clk);
        #2;
    endtask

    task automatic send_bit(input logic lr, input logic d);
        wait_half();
        sclk  = 1'b0;
        lrclk = lr;
        din   = d;
        wait_half();
        sclk  = 1'b1;
    endtask

    task automatic send_channel(input logic lr, input logic [15:0] data, input int payload, input bit is_right);
        logic [31:0] junk;
        junk = $urandom;
        send_bit(lr, junk[31]);
        if (is_right) -> right_start_ev;
        for (int i = 0; i < payload; i++) begin
            send_bit(lr, (i < 16) ? data[15 - i] : junk[i % 31]);
            if (is_right && i == 15) begin
                last_bit_time = $realtime;
                -> last_right_bit_ev;
            end
        end
    endtask

    task automatic applyStimulus(input logic [15:0] l, input logic [15:0] r, input int payload);
        send_channel(1'b0, l, payload, 1'b0);
        send_channel(1'b1, r, payload, 1'b1);
    endtask

    task automatic lead_in(input int n);
        logic [31:0] junk;
        junk = $urandom;
        for (int i = 0; i < n; i++) begin
            send_bit(1'b1, junk[i]);
        end
    endtask

    task automatic set_ready(input logic v);
        @(posedge Clk);
        #2;
        out_ready16 = v;
    endtask

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation did not reach its end (time %0t)", $time);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [15:0] rl, rr;
        Reset       = 1'b1;
        sclk        = 1'b0;
        lrclk       = 1'b0;
        din         = 1'b0;
        out_ready16 = 1'b1;
        repeat (3) @(posedge Clk);
        #2;
        Reset = 1'b0;
        @(negedge Clk);
        $display("[TB] reset state");
        checkOutput("reset_valid", {31'h0, out_valid16}, 32'h0);
        checkOutput("reset_left", {16'h0, out_left16}, 32'h0);
        checkOutput("reset_right", {16'h0, out_right16}, 32'h0);
        checkOutput("reset_valid24", {31'h0, out_valid24}, 32'h0);
`ifdef I2S_RX_OVERRUN_EN
        checkOutput("reset_overrun", {31'h0, overrun16}, 32'h0);
`endif

        $display("[TB] start mid-right channel, then A5C3/0F01");
        lead_in(9);
        exp_q.push_back('{l: 16'hA5C3, r: 16'h0F01});
        applyStimulus(16'hA5C3, 16'h0F01, 32);
        repeat (8) @(posedge Clk);
        @(negedge Clk);
        checkOutput("latency_le_5clk",
                    {31'h0, (valid_rise_time > last_bit_time) && (valid_rise_time - last_bit_time <= 100.0)}, 32'h1);
        checkOutput("valid_single_pulse", {31'h0, out_valid16}, 32'h0);

        $display("[TB] back-to-back frames with boundary and random data");
        exp_q.push_back('{l: 16'hFFFF, r: 16'h0000});
        applyStimulus(16'hFFFF, 16'h0000, 32);
        for (int k = 0; k < 3; k++) begin
            rl = 16'($urandom);
            rr = 16'($urandom);
            exp_q.push_back('{l: rl, r: rr});
            applyStimulus(rl, rr, 32);
        end

        $display("[TB] frame completes while held frame is being accepted");
        set_ready(1'b0);
        exp_q.push_back('{l: 16'h1357, r: 16'h2468});
        exp_q.push_back('{l: 16'hBEEF, r: 16'hCAFE});
        applyStimulus(16'h1357, 16'h2468, 32);
        @(negedge Clk);
        checkOutput("held_before_coincide", {16'h0, out_left16}, 32'h1357);
        fork
            applyStimulus(16'hBEEF, 16'hCAFE, 32);
            begin
                @(last_right_bit_ev);
                @(posedge Clk);
                @(posedge Clk);
                #2;
                out_ready16 = 1'b1;
                @(posedge Clk);
                #2;
                out_ready16 = 1'b0;
            end
        join
        @(negedge Clk);
        checkOutput("coincide_valid_stays", {31'h0, out_valid16}, 32'h1);
        checkOutput("coincide_new_left", {16'h0, out_left16}, 32'hBEEF);
        checkOutput("coincide_new_right", {16'h0, out_right16}, 32'hCAFE);
`ifdef I2S_RX_OVERRUN_EN
        checkOutput("coincide_no_overrun", {31'h0, overrun16}, 32'h0);
`endif
        set_ready(1'b1);
        repeat (3) @(posedge Clk);

        $display("[TB] out_ready low across two frames");
        set_ready(1'b0);
        exp_q.push_back('{l: 16'h1111, r: 16'h2222});
        applyStimulus(16'h1111, 16'h2222, 32);
        applyStimulus(16'h3333, 16'h4444, 32);
        @(negedge Clk);
        checkOutput("stall_valid", {31'h0, out_valid16}, 32'h1);
        checkOutput("stall_left", {16'h0, out_left16}, 32'h1111);
        checkOutput("stall_right", {16'h0, out_right16}, 32'h2222);
`ifdef I2S_RX_OVERRUN_EN
        checkOutput("stall_overrun", {31'h0, overrun16}, 32'h1);
`endif
        set_ready(1'b1);
        repeat (3) @(posedge Clk);
        @(negedge Clk);
        checkOutput("stall_released_valid", {31'h0, out_valid16}, 32'h0);
        exp_q.push_back('{l: 16'h5555, r: 16'h6666});
        applyStimulus(16'h5555, 16'h6666, 32);

        $display("[TB] reset pulse during right channel");
        fork
            applyStimulus(16'h7777, 16'h8888, 32);
            begin
                @(right_start_ev);
                repeat (40) @(posedge Clk);
                #2;
                Reset = 1'b1;
                @(posedge Clk);
                #2;
                Reset = 1'b0;
                @(negedge Clk);
                checkOutput("rst_mid_valid", {31'h0, out_valid16}, 32'h0);
                checkOutput("rst_mid_left", {16'h0, out_left16}, 32'h0);
                checkOutput("rst_mid_right", {16'h0, out_right16}, 32'h0);
`ifdef I2S_RX_OVERRUN_EN
                checkOutput("rst_mid_overrun", {31'h0, overrun16}, 32'h0);
`endif
            end
        join
        exp_q.push_back('{l: 16'h9ABC, r: 16'hDEF0});
        applyStimulus(16'h9ABC, 16'hDEF0, 32);

        $display("[TB] 16-bit slots into the 24-bit instance");
        armed24 = 1'b1;
        exp_q.push_back('{l: 16'h8001, r: 16'h1234});
        exp_q.push_back('{l: 16'hAAAA, r: 16'h5555});
        applyStimulus(16'h8001, 16'h1234, 16);
        applyStimulus(16'hAAAA, 16'h5555, 16);
        repeat (20) @(posedge Clk);
        @(negedge Clk);
        checkOutput("dw24_frame_seen", {31'h0, got24}, 32'h1);
        checkOutput("dw24_left_zero_fill", {8'h0, left24}, 32'h0080_0100);
        checkOutput("dw24_right_zero_fill", {8'h0, right24}, 32'h0012_3400);

        repeat (10) @(posedge Clk);
        checkOutput("scoreboard_drained", exp_q.size(), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule

// File: doc/i2s_rx_deser.md
I2S_RX_DESER -- requirements
Module: i2s_rx_deser

Interface
REQ-001 SHALL have parameter DATA_W, default 16, the captured bits per channel (legal range 8..32).
REQ-002 SHALL have port Clk, input, 1, the 50 MHz system clock; Clk is the block's only clock.
REQ-003 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-004 SHALL have port sclk_in, input, 1, the codec bit clock; the codec is master, and this input is asynchronous to Clk.
REQ-005 SHALL have port lrclk_in, input, 1, the codec word select (0 = left, 1 = right); asynchronous.
REQ-006 SHALL have port din_in, input, 1, codec serial ADC data, MSB first; asynchronous.
REQ-007 SHALL have port out_left, output, DATA_W, left sample of the held frame.
REQ-008 SHALL have port out_right, output, DATA_W, right sample of the held frame.
REQ-009 SHALL have port out_valid, output, 1, high while a frame is held.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts the frame.
REQ-011 SHALL have port overrun, output, 1, sticky dropped-frame flag; present only under I2S_RX_OVERRUN_EN.

Function
REQ-012 SHALL pass sclk_in, lrclk_in and din_in each through a 2-flop synchronizer clocked by Clk.
REQ-013 SHALL detect an sclk rising edge as a Clk cycle where synced sclk is 1 and its previous sample is 0, and SHALL sample synced lrclk and din only in that cycle.
REQ-014 SHALL guarantee correct capture for sclk frequency up to Clk/8.
REQ-015 SHALL treat a rise whose sampled lrclk differs from the lrclk sampled at the previous rise as the I2S delay slot; that bit is discarded and a new channel starts at the next rise.
REQ-016 SHALL implement an FSM with these states and transitions:
- ALIGN: wait for a delay slot with lrclk = 0, then go to SHIFT_L.
- SHIFT_L: shift DATA_W bits MSB-first, then go to WAIT_L.
- WAIT_L: ignore bits until a delay slot with lrclk = 1, then go to SHIFT_R.
- SHIFT_R: shift DATA_W bits, then go to WAIT_R and assert frame_done.
- WAIT_R: ignore bits until a delay slot with lrclk = 0, then go to SHIFT_L.
REQ-017 SHALL, when a delay slot occurs during a SHIFT state (slot shorter than DATA_W), left-justify the bits captured so far, zero-fill the LSBs, and complete that channel as if DATA_W bits had arrived; the delay slot also starts the next channel.
REQ-018 SHALL, when a delay slot with unexpected lrclk occurs in SHIFT_L or WAIT_L (a right channel without a left end), discard the partial frame and go to ALIGN.
REQ-019 SHALL handle frame_done as follows:
- If out_valid = 0, or out_valid and out_ready are both 1 in the same cycle, load out_left/out_right and set out_valid = 1 on the next Clk.
- Otherwise, drop the new frame and keep the held frame unchanged.
REQ-020 SHALL clear out_valid on a cycle with out_valid = 1, out_ready = 1 and no frame_done in that cycle.
REQ-021 SHALL keep out_left and out_right stable while out_valid = 1 and out_ready = 0.
REQ-022 SHALL raise out_valid no more than 5 Clk cycles after the sclk_in pin edge that carries the last right-channel bit.
REQ-023 SHALL treat out_ready as don't-care while out_valid = 0.

Reset
REQ-024 SHALL, on Reset = 1 at a Clk edge, set: FSM = ALIGN, synchronizers = 0, shift registers = 0, out_left = 0, out_right = 0, out_valid = 0, overrun = 0.
REQ-025 SHALL treat Reset asserted mid-channel or mid-frame as aborting it: no partial frame is emitted, and capture resumes only at the next left-channel delay slot.

Configuration
REQ-026 SHALL, when I2S_RX_OVERRUN_EN is defined, include port overrun, which sets to 1 one Clk after a frame is dropped per REQ-019 and clears only on Reset.
REQ-027 SHALL, when I2S_RX_OVERRUN_EN is undefined, omit port overrun and its logic; dropping behaviour is otherwise identical.

Verification
REQ-028 Bench SHALL cover: Clk 50 MHz, sclk 3.072 MHz, 32-bit slots, DATA_W = 16, left = 16'hA5C3, right = 16'h0F01, out_ready = 1 -> out_valid pulses once per frame with out_left = A5C3 and out_right = 0F01, no more than 5 Clk after the last right bit.
REQ-029 Bench SHALL cover: DATA_W = 24 with 16-bit slots, left = 16'h8001 -> out_left = 24'h800100 (zero-filled LSBs).
REQ-030 Bench SHALL cover: out_ready held 0 across two frames (F1 = 1111/2222, F2 = 3333/4444) -> outputs stay 1111/2222; overrun = 1 with the macro defined; when out_ready is released, F1 is accepted and the next frame captured is F3.
REQ-031 Bench SHALL cover: stimulus starting mid-right-channel after reset -> no output until the first complete left+right pair; the first frame is correct.
REQ-032 Bench SHALL cover: Reset pulsed 1 cycle during SHIFT_R -> no frame is emitted for the interrupted pair; the next full frame is correct and all outputs are 0 in the cycle after reset.
REQ-033 Bench SHALL cover: frame_done coincident with out_valid = 1 and out_ready = 1 -> the new frame is loaded, out_valid stays 1, and no overrun is flagged.
